seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle restoring divider answering the ALU's DIV/DIVU start/done handshake.
//   The ALU raises validIn and stalls the pipeline.
//   The divider captures the operands and iterates one quotient bit per cycle.
//   It then pulses validOut with MIPS results: Lo = quotient, Hi = remainder.
//   The ALU copies Hi/Lo into its architectural HI/LO registers.
// PARAMETERS
//   WIDTH  32  operand / result width in bits; iteration count equals WIDTH
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   reset     in   1      synchronous, active-high reset
//   validIn   in   1      start request; sampled only in IDLE
//   sign      in   1      1 = DIV (two's complement), 0 = DIVU; sampled with validIn
//   SrcA      in   WIDTH  dividend; sampled with validIn
//   SrcB      in   WIDTH  divisor; sampled with validIn
//   validOut  out  1      one-cycle done pulse; Hi/Lo are valid while it is high
//   Hi        out  WIDTH  remainder (registered)
//   Lo        out  WIDTH  quotient (registered)
// BEHAVIOUR
//   Reset: state=IDLE, validOut=0, Hi=0, Lo=0, counter=0. Any state aborts to IDLE, no pulse.
//   States and transitions:
//     IDLE : if validIn=1 -> latch operands, sign, divz=(SrcB==0) -> BUSY, count=0
//     BUSY : one restoring step per cycle; count==WIDTH-1 -> FIXUP
//     FIXUP: apply signs, write Hi/Lo registers -> DONE
//     DONE : validOut=1 for exactly this cycle; validIn ignored -> IDLE
//   Latency:
//     validIn is sampled high at edge E; validOut is high in the cycle after edge E+WIDTH+1.
//     For WIDTH=32 that is 34 stall cycles including the request cycle.
//   Operand stability:
//     Operands are captured once at the start edge.
//     SrcA/SrcB/sign changes during BUSY, FIXUP or DONE have no effect.
//     validIn dropping during BUSY does not cancel the operation.
//   Back-to-back:
//     validIn high in the cycle after DONE starts a new operation.
//     No minimum gap beyond the DONE->IDLE cycle.
//   Output hold:
//     Hi/Lo hold the last result until the next FIXUP or reset.
//     validOut is 0 in every state except DONE.
//   Arithmetic:
//     Unsigned: restoring shift-subtract on WIDTH-bit magnitudes, (WIDTH+1)-bit partial remainder.
//     Signed: divide |SrcA| by |SrcB|, truncating toward zero.
//       Quotient negated if SrcA[MSB]^SrcB[MSB]; remainder takes the sign of SrcA.
//   Signed overflow: 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (falls out of magnitude math).
//   Divide by zero (divz, either sign):
//     Lo=all ones, Hi=SrcA as captured; latency unchanged.
//     The iteration still runs; FIXUP overrides the result.
//   No exceptions are raised; the divider never stalls beyond the fixed latency.
// TESTING
//   1. DIVU 100/7 -> validOut exactly 33 edges after start edge; Lo=14, Hi=2.
//   2. DIV -7/2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
//      DIV 7/-2 -> Lo=0xFFFFFFFD, Hi=1.
//   3. 0xFFFFFFFF/1: DIVU -> Lo=0xFFFFFFFF, Hi=0; DIV -> Lo=0xFFFFFFFF, Hi=0.
//      DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
//   4. Divide by zero: DIVU 0x1234/0 and DIV -5/0 -> Lo=0xFFFFFFFF, Hi=0x1234 and 0xFFFFFFFB.
//   5. Start DIVU 100/7, assert reset at BUSY count=10 -> next cycle IDLE, Hi=Lo=0, no validOut.
//      A new start of 9/3 then gives Lo=3, Hi=0.
//   6. Hold validIn high through completion, changing SrcA mid-BUSY:
//      result reflects the captured operands; validOut is a single-cycle pulse.
//      A second operation starts on the first cycle after DONE.

Source files
------------

// File: rtl/seq_divider_if.sv
// Start/done handshake between the ALU and the sequential divider.
// The ALU drives the request and operands (master); the divider returns the HI/LO results.
interface seq_divider_if #(parameter int WIDTH = 32);
  logic             validIn;
  logic             sign;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             validOut;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (output validIn, sign, SrcA, SrcB, input validOut, Hi, Lo);
  modport slave  (input validIn, sign, SrcA, SrcB, output validOut, Hi, Lo);
endinterface

// File: rtl/seq_divider.sv
// Restoring DIV/DIVU, one quotient bit per cycle; validOut pulses WIDTH+1 edges after the start edge.
// No backpressure: validIn is sampled only in IDLE, and the result is held on Hi/Lo until the next FIXUP.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  dif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             vout_q, vout_d;

  // Restoring step: shift the next dividend bit in, keep the difference if it did not borrow.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, div_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    a_d     = a_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    vout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dif.validIn) begin
          a_d     = dif.SrcA;
          quo_d   = (dif.sign && dif.SrcA[WIDTH-1]) ? -dif.SrcA : dif.SrcA;
          div_d   = (dif.sign && dif.SrcB[WIDTH-1]) ? -dif.SrcB : dif.SrcB;
          rem_d   = '0;
          qneg_d  = dif.sign & (dif.SrcA[WIDTH-1] ^ dif.SrcB[WIDTH-1]);
          rneg_d  = dif.sign & dif.SrcA[WIDTH-1];
          divz_d  = (dif.SrcB == '0);
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (diff[WIDTH]) begin
          rem_d = shifted[WIDTH-1:0];
        end else begin
          rem_d = diff[WIDTH-1:0];
        end
        quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        // Divide by zero overrides whatever the iteration produced.
        if (divz_q) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
        vout_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      vout_q  <= vout_d;
    end
  end

  assign dif.validOut = vout_q;
  assign dif.Hi       = hi_q;
  assign dif.Lo       = lo_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signed/unsigned results, divide-by-zero, reset abort, operand capture.
module tb_seq_divider;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   edges;
  int   pulses;

  seq_divider_if #(.WIDTH(32)) dif ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts edges after the start edge until validOut is seen (bounded).
  task automatic wait_done();
    edges = 0;
    while (dif.validOut !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    @(negedge clk);
    dif.validIn = 1'b1;
    dif.sign    = sgn;
    dif.SrcA    = a;
    dif.SrcB    = b;
    @(posedge clk);
    #1;
    dif.validIn = 1'b0;
    dif.SrcA    = ~a;
    dif.SrcB    = ~b;
    dif.sign    = ~sgn;
    wait_done();
    chk({tag, "_lat"}, 32'(edges), 32'd33);
    chk({tag, "_lo"}, dif.Lo, exp_lo);
    chk({tag, "_hi"}, dif.Hi, exp_hi);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, dif.validOut}, 32'd0);
    chk({tag, "_hold"}, dif.Lo, exp_lo);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    dif.validIn = 1'b0;
    dif.sign    = 1'b0;
    dif.SrcA    = '0;
    dif.SrcB    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vout", {31'd0, dif.validOut}, 32'd0);
    chk("rst_hi", dif.Hi, 32'd0);
    chk("rst_lo", dif.Lo, 32'd0);
    reset = 1'b0;

    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_op("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_op("div_m1_1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_5_10", 1'b0, 32'd5, 32'd10, 32'd0, 32'd5);
    run_op("divu_z", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
    run_op("div_z", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // Reset abort at BUSY count=10.
    @(negedge clk);
    dif.validIn = 1'b1;
    dif.sign    = 1'b0;
    dif.SrcA    = 32'd100;
    dif.SrcB    = 32'd7;
    @(posedge clk);
    #1;
    dif.validIn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_hi", dif.Hi, 32'd0);
    chk("abort_lo", dif.Lo, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (dif.validOut === 1'b1) pulses++;
      @(posedge clk);
      #1;
    end
    chk("abort_nopulse", 32'(pulses), 32'd0);
    run_op("after_abort", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

    // validIn held high, operands changed mid-BUSY, back-to-back restart.
    @(negedge clk);
    dif.validIn = 1'b1;
    dif.sign    = 1'b0;
    dif.SrcA    = 32'd20;
    dif.SrcB    = 32'd3;
    @(posedge clk);
    #1;
    edges = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      edges++;
    end
    dif.SrcA = 32'd999;
    dif.sign = 1'b1;
    while (dif.validOut !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("hold_lat", 32'(edges), 32'd33);
    chk("hold_lo", dif.Lo, 32'd6);
    chk("hold_hi", dif.Hi, 32'd2);
    dif.SrcA = 32'd50;
    dif.SrcB = 32'd7;
    dif.sign = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_pulse", {31'd0, dif.validOut}, 32'd0);
    @(posedge clk);
    #1;
    dif.validIn = 1'b0;
    wait_done();
    chk("b2b_lat", 32'(edges), 32'd33);
    chk("b2b_lo", dif.Lo, 32'd7);
    chk("b2b_hi", dif.Hi, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_pulse", {31'd0, dif.validOut}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
